// File: rtl/rhs_pkg.sv
// Shared constants and types for the rhs_256 frame packer.
package rhs_pkg;

  localparam int unsigned NUM_CHIPS         = 16;
  localparam int unsigned CHANNELS_PER_CHIP = 16;
  localparam int unsigned LANE_W            = 16;
  localparam int unsigned SET_W             = NUM_CHIPS * LANE_W;
  localparam int unsigned WORDS_PER_SET     = SET_W / 32;
  localparam int unsigned HDR_WORDS         = 2;
  localparam int unsigned DATA_WORDS        = CHANNELS_PER_CHIP * WORDS_PER_SET;
  localparam int unsigned FRAME_WORDS       = HDR_WORDS + DATA_WORDS;

  localparam logic [31:0] MAGIC_DEFAULT = 32'h5EE6_0100;
  localparam logic [31:0] FILL_DEFAULT  = 32'hFFFF_FFFF;

  typedef logic [3:0] chan_t;

  // One buffered sample set, or an abort marker when abort=1.
  typedef struct packed {
    logic             abort;
    chan_t            channel;
    logic [SET_W-1:0] data;
  } entry_t;

  typedef enum logic {
    IN_IDLE,
    IN_COLLECT
  } in_state_t;

  typedef enum logic [1:0] {
    HDR0,
    HDR1,
    DATA
  } out_state_t;

endpackage

// File: rtl/rhs_set_fifo.sv
// Synchronous sample-set FIFO with up to two writes per cycle
// (abort marker followed by a restarting channel-0 set).
module rhs_set_fifo
  import rhs_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push0,
  input  entry_t                   entry0,
  input  logic                     push1,
  input  entry_t                   entry1,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

  // Storage writes; entry1 lands in the slot after entry0 when both push.
  always_ff @(posedge clk) begin
    if (push0) mem[wr_ptr] <= entry0;
    if (push1) mem[wr_ptr + AW'(push0)] <= entry1;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop);
    end
  end

endmodule

// File: rtl/rhs_frame_packer.sv
// Packs per-channel sample sets from rhs_256 into 130-word framed streams
// (MAGIC, frame count, 128 data words), padding frames on sequence breaks.
module rhs_frame_packer
  import rhs_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] MAGIC      = MAGIC_DEFAULT,
  parameter logic [31:0] FILL_WORD  = FILL_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         in_valid,
  input  logic [7:0]   in_channel,
  input  logic [255:0] in_data,
  output logic [31:0]  out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic [31:0]  frame_count,
  output logic         overflow,
  output logic         seq_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  in_state_t  in_state, in_state_n;
  chan_t      expected, expected_n;
  logic       in_amp, data_try, data_push, abort_push, seq_err_n, ovf_set;
  logic       push0, push1, pop, empty;
  entry_t     entry0, entry1, head, set_entry, marker;
  logic [CW-1:0] count, occ;

  out_state_t out_state, out_state_n;
  logic [6:0] idx, idx_n;
  logic       fill, fill_n, load, last_n, can_load;
  logic [31:0] word_n;

  rhs_set_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push0  (push0),
    .entry0 (entry0),
    .push1  (push1),
    .entry1 (entry1),
    .pop    (pop),
    .head   (head),
    .count  (count),
    .empty  (empty)
  );

  // Input FSM: channel-sequence tracking and FIFO push decisions.
  // One slot stays reserved for markers, so data pushes stop at DEPTH-1 entries;
  // a restart on channel 0 writes the marker and the new set in the same cycle.
  always_comb begin
    set_entry         = '0;
    set_entry.channel = in_channel[3:0];
    set_entry.data    = in_data;
    marker            = '0;
    marker.abort      = 1'b1;
    in_amp     = in_valid && (in_channel < 8'(CHANNELS_PER_CHIP));
    occ        = count - CW'(pop);
    data_try   = 1'b0;
    abort_push = 1'b0;
    seq_err_n  = 1'b0;
    ovf_set    = 1'b0;
    in_state_n = in_state;
    expected_n = expected;
    if (in_amp) begin
      if (in_state == IN_IDLE) begin
        data_try = (in_channel[3:0] == '0) && enable;
      end else if (in_channel[3:0] == expected) begin
        data_try = 1'b1;
      end else begin
        abort_push = 1'b1;
        seq_err_n  = 1'b1;
        data_try   = (in_channel[3:0] == '0) && enable;
      end
    end
    data_push = data_try && ((occ + CW'(abort_push)) < CW'(FIFO_DEPTH - 1));
    if (data_try && !data_push) begin
      ovf_set = 1'b1;
      if ((in_state == IN_COLLECT) && !abort_push) begin
        abort_push = 1'b1;
        seq_err_n  = 1'b1;
      end
    end
    if (data_push) begin
      in_state_n = (in_channel[3:0] == 4'(CHANNELS_PER_CHIP - 1)) ? IN_IDLE : IN_COLLECT;
      expected_n = in_channel[3:0] + 4'd1;
    end else if (abort_push) begin
      in_state_n = IN_IDLE;
      expected_n = '0;
    end
    push0  = abort_push || data_push;
    entry0 = abort_push ? marker : set_entry;
    push1  = abort_push && data_push;
    entry1 = set_entry;
  end

  // Input FSM state and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_state <= IN_IDLE;
      expected <= '0;
      seq_err  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      in_state <= in_state_n;
      expected <= expected_n;
      seq_err  <= seq_err_n;
      if (ovf_set) overflow <= 1'b1;
    end
  end

  // Output FSM: picks the next word to load into the output register.
  always_comb begin
    can_load    = !out_valid || out_ready;
    pop         = 1'b0;
    load        = 1'b0;
    word_n      = out_data;
    last_n      = 1'b0;
    out_state_n = out_state;
    idx_n       = idx;
    fill_n      = fill;
    case (out_state)
      HDR0: begin
        if (!empty) begin
          if (head.abort || (head.channel != '0)) begin
            pop = 1'b1;
          end else if (can_load) begin
            load        = 1'b1;
            word_n      = MAGIC;
            out_state_n = HDR1;
          end
        end
      end
      HDR1: begin
        if (can_load) begin
          load        = 1'b1;
          word_n      = frame_count;
          out_state_n = DATA;
          idx_n       = '0;
          fill_n      = 1'b0;
        end
      end
      DATA: begin
        if (can_load) begin
          if (fill) begin
            load   = 1'b1;
            word_n = FILL_WORD;
          end else if (!empty) begin
            load = 1'b1;
            if (head.abort) begin
              pop    = 1'b1;
              fill_n = 1'b1;
              word_n = FILL_WORD;
            end else begin
              word_n = head.data[{idx[2:0], 5'd0} +: 32];
              pop    = (idx[2:0] == 3'(WORDS_PER_SET - 1));
            end
          end
          if (load) begin
            idx_n = idx + 7'd1;
            if (idx == 7'(DATA_WORDS - 1)) begin
              last_n      = 1'b1;
              out_state_n = HDR0;
            end
          end
        end
      end
      default: out_state_n = HDR0;
    endcase
  end

  // Output register and output FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_state <= HDR0;
      idx       <= '0;
      fill      <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_state <= out_state_n;
      idx       <= idx_n;
      fill      <= fill_n;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= word_n;
        out_last  <= last_n;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  // Completed-frame counter, advanced on the transfer of the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
    end else if (out_valid && out_ready && out_last) begin
      frame_count <= frame_count + 32'd1;
    end
  end

endmodule
